rx_frame_assembler: RTL and testbench

- Sits directly downstream of the RX word aligner; consumes its aligned word stream, start-of-frame strobe and aligned flag.
- Collects FRAME_WIDTH/DWIDTH aligned words into one frame and strips and decodes the 2-bit sync header.
- Emits one frame-valid pulse per complete frame, with a data/control flag and a header-error flag, to the RX frame decoder.
- Maintains saturating header-error and dropped-frame statistics counters.

---
 rtl/rifl_rx_pkg.sv | 29 ++
 rtl/rx_descrambler.sv | 62 ++++++
 rtl/rx_frame_assembler.sv | 171 +++++++++++++++++
 tb/tb_rx_frame_assembler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rifl_rx_pkg.sv
// Shared types and constants for the RX frame path: sync-header encodings,
// assembler state encoding and descrambler taps.
package rifl_rx_pkg;

    typedef logic [1:0] hdr_t;

    localparam hdr_t HDR_DATA = 2'b01;
    localparam hdr_t HDR_CTRL = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

    localparam int SCR_TAP1 = 39;
    localparam int SCR_TAP2 = 58;

    // Returns {is_ctrl, hdr_err} for a 2-bit sync header.
    function automatic logic [1:0] decode_hdr(input hdr_t hdr);
        logic [1:0] res;
        case (hdr)
            HDR_DATA: res = 2'b00;
            HDR_CTRL: res = 2'b10;
            default:  res = 2'b01;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rx_descrambler.sv
// Self-synchronous descrambler (1 + x^39 + x^58), wire order MSB first.
// The two header bits of a sof word bypass it and leave the state untouched.
module rx_descrambler
    import rifl_rx_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              valid_i,
    input  logic              hdr_bypass_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic              hdr_bypass_o
);

    logic [SCR_TAP2-1:0] scr_q, scr_d;
    logic [DWIDTH-1:0]   data_q, data_d;
    logic                valid_q;
    logic                bypass_q;

    // Bit-serial unroll of the descrambler over one word
    always_comb begin
        logic [SCR_TAP2-1:0] st;
        st     = scr_q;
        data_d = data_i;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (hdr_bypass_i && (i >= DWIDTH - 2)) begin
                data_d[i] = data_i[i];
            end else begin
                data_d[i] = data_i[i] ^ st[SCR_TAP1-1] ^ st[SCR_TAP2-1];
                st        = {st[SCR_TAP2-2:0], data_i[i]};
            end
        end
        if (valid_i) begin
            scr_d = st;
        end else begin
            scr_d = scr_q;
        end
    end

    // Descrambler state and the added pipeline stage
    always_ff @(posedge clk) begin
        if (rst) begin
            scr_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            scr_q    <= scr_d;
            data_q   <= data_d;
            valid_q  <= valid_i;
            bypass_q <= hdr_bypass_i;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign hdr_bypass_o = bypass_q;

endmodule

// File: rtl/rx_frame_assembler.sv
// Collects aligned words into frames, strips/decodes the sync header and keeps
// saturating error/drop statistics. Optional descrambler: RX_DESCRAMBLE_EN.
module rx_frame_assembler
    import rifl_rx_pkg::*;
#(
    parameter int DWIDTH      = 64,
    parameter int FRAME_WIDTH = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DWIDTH-1:0]      rxdata_in,
    input  logic                   sof_in,
    input  logic                   rx_aligned_in,
    output logic [FRAME_WIDTH-3:0] frame_data,
    output logic                   frame_valid,
    output logic                   frame_is_ctrl,
    output logic                   frame_hdr_err,
    output logic [CNT_WIDTH-1:0]   hdr_err_cnt,
    output logic [CNT_WIDTH-1:0]   drop_cnt
);

    localparam int N_FRAME_CYCLE = FRAME_WIDTH / DWIDTH;
    localparam int IDX_W         = (N_FRAME_CYCLE > 1) ? $clog2(N_FRAME_CYCLE) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_FRAME_CYCLE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [DWIDTH-1:0] word_s;
    logic              sof_s;
    logic              aligned_s;

`ifdef RX_DESCRAMBLE_EN
    rx_descrambler #(
        .DWIDTH(DWIDTH)
    ) u_descrambler (
        .clk          (clk),
        .rst          (rst),
        .data_i       (rxdata_in),
        .valid_i      (rx_aligned_in),
        .hdr_bypass_i (sof_in),
        .data_o       (word_s),
        .valid_o      (aligned_s),
        .hdr_bypass_o (sof_s)
    );
`else
    assign word_s    = rxdata_in;
    assign sof_s     = sof_in;
    assign aligned_s = rx_aligned_in;
`endif

    asm_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_WIDTH-1:0] buf_q, buf_d;
    logic                   done_s;
    logic                   drop_s;

    logic [FRAME_WIDTH-3:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ctrl_q, ctrl_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [1:0]             dec_s;

    // State, frame buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            buf_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            err_q      <= 1'b0;
            hdr_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            err_q      <= err_d;
            hdr_cnt_q  <= hdr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next state: word placement (first word lands in the MSBs), completion, aborts
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        done_s  = 1'b0;
        drop_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_s && sof_s) begin
                    buf_d[(N_FRAME_CYCLE-1)*DWIDTH +: DWIDTH] = word_s;
                    if (N_FRAME_CYCLE == 1) begin
                        done_s = 1'b1;
                        idx_d  = '0;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = COLLECT;
                    end
                end else begin
                    idx_d = '0;
                end
            end
            COLLECT: begin
                if (!aligned_s) begin
                    drop_s  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (sof_s) begin
                    drop_s = 1'b1;
                    buf_d[(N_FRAME_CYCLE-1)*DWIDTH +: DWIDTH] = word_s;
                    idx_d  = IDX_W'(1);
                end else begin
                    buf_d[(N_FRAME_CYCLE-1-int'(idx_q))*DWIDTH +: DWIDTH] = word_s;
                    if (idx_q == LAST_IDX) begin
                        done_s  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: latch the completed frame and bump the saturating counters
    always_comb begin
        dec_s   = decode_hdr(buf_d[FRAME_WIDTH-1 -: 2]);
        valid_d = done_s;
        if (done_s) begin
            data_d = buf_d[FRAME_WIDTH-3:0];
            ctrl_d = dec_s[1];
            err_d  = dec_s[0];
        end else begin
            data_d = data_q;
            ctrl_d = ctrl_q;
            err_d  = err_q;
        end
        if (done_s && dec_s[0] && (hdr_cnt_q != CNT_MAX)) begin
            hdr_cnt_d = hdr_cnt_q + CNT_WIDTH'(1);
        end else begin
            hdr_cnt_d = hdr_cnt_q;
        end
        if (drop_s && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    assign frame_data    = data_q;
    assign frame_valid   = valid_q;
    assign frame_is_ctrl = ctrl_q;
    assign frame_hdr_err = err_q;
    assign hdr_err_cnt   = hdr_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: a 4-word/frame instance with 4-bit counters and a
// 1-word/frame instance; frames are checked against a scoreboard of expected frames.
module tb_rx_frame_assembler;

    localparam int DW  = 64;
    localparam int FW  = 256;
    localparam int NW  = FW / DW;
    localparam int CW  = 4;
    localparam int CW1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] rxdata;
    logic          sof;
    logic          aligned;
    logic [FW-3:0] frame_data;
    logic          frame_valid, frame_is_ctrl, frame_hdr_err;
    logic [CW-1:0] hdr_err_cnt, drop_cnt;

    logic [DW-1:0]  rxdata1;
    logic           sof1;
    logic           aligned1;
    logic [DW-3:0]  frame_data1;
    logic           frame_valid1, frame_is_ctrl1, frame_hdr_err1;
    logic [CW1-1:0] hdr_err_cnt1, drop_cnt1;

    rx_frame_assembler #(.DWIDTH(DW), .FRAME_WIDTH(FW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .rxdata_in(rxdata), .sof_in(sof), .rx_aligned_in(aligned),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_is_ctrl(frame_is_ctrl),
        .frame_hdr_err(frame_hdr_err), .hdr_err_cnt(hdr_err_cnt), .drop_cnt(drop_cnt)
    );

    rx_frame_assembler #(.DWIDTH(DW), .FRAME_WIDTH(DW), .CNT_WIDTH(CW1)) u_dut1 (
        .clk(clk), .rst(rst), .rxdata_in(rxdata1), .sof_in(sof1), .rx_aligned_in(aligned1),
        .frame_data(frame_data1), .frame_valid(frame_valid1), .frame_is_ctrl(frame_is_ctrl1),
        .frame_hdr_err(frame_hdr_err1), .hdr_err_cnt(hdr_err_cnt1), .drop_cnt(drop_cnt1)
    );

    typedef struct {
        logic [FW-3:0] data;
        logic          ctrl;
        logic          err;
        int            due;
    } exp_t;

    typedef struct {
        logic [1:0] hdr;
        logic       exp_ctrl;
        logic       exp_err;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   seed = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the 4-word instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_frame_valid: got none expected at cycle %0d", sb[0].due);
                void'(sb.pop_front());
            end
            if (frame_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_frame_valid: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("valid_cycle", 256'(cyc), 256'(e.due));
                    check("frame_data", 256'(frame_data), 256'(e.data));
                    check("frame_is_ctrl", 256'(frame_is_ctrl), 256'(e.ctrl));
                    check("frame_hdr_err", 256'(frame_hdr_err), 256'(e.err));
                end
            end
        end
    end

    task automatic drive(input logic [DW-1:0] w, input logic s, input logic a);
        @(negedge clk);
        rxdata  = w;
        sof     = s;
        aligned = a;
    endtask

    function automatic logic [DW-1:0] mkword(input int sd, input int k);
        logic [31:0] v;
        v = 32'(sd * 16 + k);
        return {v, 32'hC0DE0000 | v};
    endfunction

    // Drive a complete frame and register what the DUT must emit for it
    task automatic send_frame(input logic [1:0] hdr, input logic ectrl, input logic eerr);
        logic [FW-1:0] f;
        logic [DW-1:0] w;
        exp_t          e;
        f = '0;
        for (int k = 0; k < NW; k++) begin
            w = mkword(seed, k);
            if (k == 0) w[DW-1 -: 2] = hdr;
            f[FW-1-DW*k -: DW] = w;
            drive(w, (k == 0), 1'b1);
        end
        e.data = f[FW-3:0];
        e.ctrl = ectrl;
        e.err  = eerr;
        e.due  = cyc + 1;
        sb.push_back(e);
        seed++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(64'h0, 1'b0, 1'b0);
    endtask

    vec_t tbl[7];

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] prev1;
        int            exp_cnt1;

        rst = 1'b1; rxdata = '0; sof = 1'b0; aligned = 1'b0;
        rxdata1 = '0; sof1 = 1'b0; aligned1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_frame_valid", 256'(frame_valid), 256'(0));
        check("rst_frame_data", 256'(frame_data), 256'(0));
        check("rst_flags", 256'({frame_is_ctrl, frame_hdr_err}), 256'(0));
        check("rst_counters", 256'({hdr_err_cnt, drop_cnt}), 256'(0));
        check("rst_dut1", 256'({frame_valid1, frame_data1, hdr_err_cnt1, drop_cnt1}), 256'(0));
        rst = 1'b0;

        tbl[0] = '{hdr: 2'b01, exp_ctrl: 1'b0, exp_err: 1'b0};
        tbl[1] = '{hdr: 2'b10, exp_ctrl: 1'b1, exp_err: 1'b0};
        tbl[2] = '{hdr: 2'b01, exp_ctrl: 1'b0, exp_err: 1'b0};
        tbl[3] = '{hdr: 2'b10, exp_ctrl: 1'b1, exp_err: 1'b0};
        tbl[4] = '{hdr: 2'b01, exp_ctrl: 1'b0, exp_err: 1'b0};
        tbl[5] = '{hdr: 2'b11, exp_ctrl: 1'b0, exp_err: 1'b1};
        tbl[6] = '{hdr: 2'b01, exp_ctrl: 1'b0, exp_err: 1'b0};

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].hdr, tbl[i].exp_ctrl, tbl[i].exp_err);
        end
        idle(2);
        check("hdr_err_cnt_after_table", 256'(hdr_err_cnt), 256'(1));
        check("drop_cnt_after_table", 256'(drop_cnt), 256'(0));

        // Early sof on word index 2: partial frame dropped, sof word restarts
        drive(mkword(100, 0) & 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drive(mkword(100, 1), 1'b0, 1'b1);
        send_frame(2'b01, 1'b0, 1'b0);
        idle(2);
        check("drop_cnt_early_sof", 256'(drop_cnt), 256'(1));

        // Aligned lost during word index 2, back 5 cycles later with a sof
        drive(mkword(101, 0) & 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drive(mkword(101, 1), 1'b0, 1'b1);
        drive(mkword(101, 2), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(mkword(102, i), 1'b1, 1'b0);
        send_frame(2'b10, 1'b1, 1'b0);
        idle(2);
        check("drop_cnt_align_loss", 256'(drop_cnt), 256'(2));

        // sof together with aligned loss: one drop, nothing captured
        drive(mkword(103, 0) & 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drive(mkword(103, 1), 1'b0, 1'b1);
        drive(mkword(103, 2) | 64'h4000_0000_0000_0000, 1'b1, 1'b0);
        drive(mkword(103, 3), 1'b0, 1'b1);
        drive(mkword(103, 4), 1'b0, 1'b1);
        send_frame(2'b01, 1'b0, 1'b0);
        idle(2);
        check("drop_cnt_sof_and_loss", 256'(drop_cnt), 256'(3));
        check("hdr_err_cnt_unchanged", 256'(hdr_err_cnt), 256'(1));

        // 2^CW+3 errored headers: 4-bit counter must stick at 15
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            send_frame((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0, 1'b1);
        end
        idle(2);
        check("hdr_err_cnt_saturated", 256'(hdr_err_cnt), 256'(15));
        check("drop_cnt_final", 256'(drop_cnt), 256'(3));
        idle(4);
        check("scoreboard_drained", 256'(sb.size()), 256'(0));

        // Single-word frames, sof every cycle
        exp_cnt1 = 0;
        prev1    = '0;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("dut1_valid", 256'(frame_valid1), 256'(1));
                check("dut1_data", 256'(frame_data1), 256'(prev1[DW-3:0]));
                check("dut1_ctrl", 256'(frame_is_ctrl1), 256'(prev1[DW-1:DW-2] == 2'b10));
                check("dut1_err", 256'(frame_hdr_err1), 256'(prev1[DW-1] == prev1[DW-2]));
            end
            if (i < 24) begin
                w = {$urandom, $urandom};
                if (i < 4) w[DW-1 -: 2] = 2'(i);
                rxdata1  = w;
                sof1     = 1'b1;
                aligned1 = 1'b1;
                if (w[DW-1] == w[DW-2]) exp_cnt1++;
                prev1 = w;
            end else begin
                sof1     = 1'b0;
                aligned1 = 1'b0;
            end
        end
        check("dut1_hdr_err_cnt", 256'(hdr_err_cnt1), 256'(exp_cnt1));
        @(negedge clk);
        check("dut1_valid_stops", 256'(frame_valid1), 256'(0));
        check("dut1_drop_cnt", 256'(drop_cnt1), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
